// File: rtl/result_readout.sv
// rtl/result_readout.sv - sweeps the result SRAM after ALU completion and streams captured words
// through a 2-entry buffer, with busy/done status and a sticky read-timeout error.
module result_readout #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              read_n,
    output logic [ADDR_W-1:0] r_addr,
    input  logic              ry,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int WC_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [WC_W-1:0]   WC_LIMIT = WC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [DATA_W:0]   mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q;

    logic              issue_ok;
    logic              is_last;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr_calc;
    logic [WC_W-1:0]   wcnt_inc;
    logic [DATA_W:0]   head;

    // Only one read is ever outstanding, so a free slot at issue time guarantees room for the push.
    assign issue_ok  = (cnt_q != 2'd2);
    assign is_last   = (idx_q == LAST_IDX);
    assign addr_calc = BASE + ADDR_W'(idx_q);
    assign wcnt_inc  = wcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        push    = 1'b0;
        read_n  = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ok) begin
                    read_n  = 1'b0;
                    addr_d  = addr_calc;
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ry) begin
                    push = 1'b1;
                    if (is_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == WC_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == 2'd0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign pop = (cnt_q != 2'd0) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {read_data, is_last};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_valid   = (cnt_q != 2'd0);
    assign out_data    = out_valid ? head[DATA_W:1] : '0;
    assign out_last    = out_valid & head[0];
    assign r_addr      = read_n ? addr_q : addr_calc;
    assign busy        = (state_q != S_IDLE) && !done;
    assign timeout_err = err_q;

endmodule
